// File: rtl/bf_sweep_ctrl.sv
// -----------------------------------------------------------------------------
// bf_sweep_ctrl
//
// Sweep controller for the 8-bank Bellman-Ford distance BRAM array. Each
// relaxation sweep issues one read per vertex to all banks and then replays
// the vertex index as a write (address + enable) once the read and relax
// datapath latency has elapsed. Distances ping-pong between two address
// pages selected by bit 0 of the completed-sweep counter: reads come from
// page p, writes go to page ~p. A run ends early once a full sweep produces
// no change, or after MAX_ITER sweeps.
//
// Ports
//   clk             system clock
//   rst_n           asynchronous active-low reset
//   i_start         begin a run (only honoured while idle)
//   i_abort         return to idle at once; in-flight writes are discarded
//   i_dp_changed    datapath reports the value being written differs from
//                   the old one; only meaningful while o_w_en = 1
//   o_rd_addr       read address, fanned out to every bank
//   o_rd_valid      o_rd_addr is a live read this cycle
//   o_write_address shared write address for all banks
//   o_w_en          shared write enable for all banks
//   o_busy          controller is not idle
//   o_done          one-cycle pulse when a run completes
//   o_converged     held from o_done until the next start; 1 = early exit
//   o_iter_count    completed sweeps in the current / last run
// -----------------------------------------------------------------------------
module bf_sweep_ctrl #(
    parameter int N_VERT   = 8,
    parameter int ADDR_W   = 10,
    parameter int RD_LAT   = 1,
    parameter int DP_LAT   = 3,
    parameter int MAX_ITER = N_VERT - 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_start,
    input  logic              i_abort,
    input  logic              i_dp_changed,
    output logic [ADDR_W-1:0] o_rd_addr,
    output logic              o_rd_valid,
    output logic [ADDR_W-1:0] o_write_address,
    output logic              o_w_en,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_converged,
    output logic [ADDR_W-1:0] o_iter_count
);

    // Read-to-write distance in cycles.
    localparam int L  = RD_LAT + DP_LAT;
    localparam int VW = (N_VERT > 1) ? $clog2(N_VERT) : 1;

    localparam logic [ADDR_W-1:0] PAGE_MSK   = {1'b1, {(ADDR_W-1){1'b0}}};
    localparam logic [ADDR_W-1:0] MAX_ITER_W = ADDR_W'(MAX_ITER);
    localparam logic [VW-1:0]     V_LAST     = VW'(N_VERT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_READ,
        S_DRAIN,
        S_CHECK,
        S_DONE
    } state_t;

    state_t            r_state;
    logic [VW-1:0]     r_v;
    logic              r_chg;
    logic [ADDR_W-1:0] r_iter;
    logic              r_rd_valid;
    logic [ADDR_W-1:0] r_rd_addr;
    logic              r_busy;
    logic              r_done;
    logic              r_conv;

    // Write-timing delay line: one entry per read, carrying the already
    // page-flipped write address. The last stage drives the write port.
    logic [L-1:0]      r_pipe_vld;
    logic [ADDR_W-1:0] r_pipe_addr [L];

    logic              w_pipe_busy;
    logic [ADDR_W-1:0] w_iter_inc;
    logic [ADDR_W-1:0] w_wr_addr_in;

    function automatic logic [ADDR_W-1:0] page_addr(input logic p, input logic [VW-1:0] v);
        return (p ? PAGE_MSK : '0) | ADDR_W'(v);
    endfunction

    assign w_iter_inc   = r_iter + 1'b1;
    // Write page is the opposite page of the read: flip the top address bit.
    assign w_wr_addr_in = r_rd_valid ? (r_rd_addr ^ PAGE_MSK) : '0;

    // DRAIN may leave once only the final stage can still hold a write: that
    // write happens in the current cycle, so its change report is captured
    // by the flag before CHECK evaluates it.
    generate
        if (L > 1) begin : g_busy_multi
            assign w_pipe_busy = |r_pipe_vld[L-2:0];
        end else begin : g_busy_single
            assign w_pipe_busy = 1'b0;
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < L; k++) begin
                r_pipe_addr[k] <= '0;
            end
        end else if (i_abort) begin
            r_pipe_vld <= '0;
            for (int k = 0; k < L; k++) begin
                r_pipe_addr[k] <= '0;
            end
        end else begin
            r_pipe_vld[0]  <= r_rd_valid;
            r_pipe_addr[0] <= w_wr_addr_in;
            for (int k = 1; k < L; k++) begin
                r_pipe_vld[k]  <= r_pipe_vld[k-1];
                r_pipe_addr[k] <= r_pipe_addr[k-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_v        <= '0;
            r_chg      <= 1'b0;
            r_iter     <= '0;
            r_rd_valid <= 1'b0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_conv     <= 1'b0;
        end else begin
            r_done <= 1'b0;

            if (r_pipe_vld[L-1] && i_dp_changed) begin
                r_chg <= 1'b1;
            end

            if (i_abort) begin
                r_state    <= S_IDLE;
                r_rd_valid <= 1'b0;
                r_rd_addr  <= '0;
                r_busy     <= 1'b0;
                r_conv     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: begin
                        if (i_start) begin
                            r_state    <= S_READ;
                            r_iter     <= '0;
                            r_conv     <= 1'b0;
                            r_chg      <= 1'b0;
                            r_v        <= '0;
                            r_rd_valid <= 1'b1;
                            r_rd_addr  <= '0;
                            r_busy     <= 1'b1;
                        end
                    end
                    S_READ: begin
                        if (r_v == V_LAST) begin
                            r_state    <= S_DRAIN;
                            r_rd_valid <= 1'b0;
                            r_rd_addr  <= '0;
                        end else begin
                            r_v       <= r_v + 1'b1;
                            r_rd_addr <= page_addr(r_iter[0], r_v + 1'b1);
                        end
                    end
                    S_DRAIN: begin
                        if (!w_pipe_busy) begin
                            r_state <= S_CHECK;
                        end
                    end
                    S_CHECK: begin
                        r_iter <= w_iter_inc;
                        if (!r_chg) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                            r_conv  <= 1'b1;
                        end else if (w_iter_inc == MAX_ITER_W) begin
                            r_state <= S_DONE;
                            r_done  <= 1'b1;
                        end else begin
                            // Next sweep reads the page just written.
                            r_state    <= S_READ;
                            r_v        <= '0;
                            r_chg      <= 1'b0;
                            r_rd_valid <= 1'b1;
                            r_rd_addr  <= page_addr(w_iter_inc[0], '0);
                        end
                    end
                    S_DONE: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                    default: begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign o_rd_addr       = r_rd_addr;
    assign o_rd_valid      = r_rd_valid;
    assign o_write_address = r_pipe_addr[L-1];
    assign o_w_en          = r_pipe_vld[L-1];
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_converged     = r_conv;
    assign o_iter_count    = r_iter;

endmodule

// File: doc/bf_sweep_ctrl.md
Name: bf_sweep_ctrl

Overview:
- Sequences the 8-bank Bellman-Ford distance BRAM array through relaxation sweeps.
- Each sweep issues one read address per vertex to all banks, then times the datapath writeback (write_address, w_en) to land after the read and relax latency.
- Distances ping-pong between two address pages. The block counts iterations and stops early when a full sweep produces no change, or after N_VERT-1 sweeps.

Parameters:
- N_VERT, 8, number of vertices (addresses per page); power of 2, ≤ 512
- ADDR_W, 10, BRAM address width
- RD_LAT, 1, BRAM read latency (cycles)
- DP_LAT, 3, relax datapath latency from BRAM output to write data valid
- MAX_ITER, N_VERT-1, sweep limit

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  begin a run; sampled only in IDLE
- abort  in  1  return to IDLE; pending writes discarded
- dp_changed  in  1  datapath: written value differs from old value; valid when w_en=1
- rd_addr  out  ADDR_W  read address, fanned to muxra0..muxra7
- rd_valid  out  1  rd_addr is a live read this cycle
- write_address  out  ADDR_W  shared write address for all banks
- w_en  out  1  shared write enable for all banks
- busy  out  1  high in any state other than IDLE
- done  out  1  one-cycle pulse on completion
- converged  out  1  held from done until next start; 1 = early exit (no change in a sweep)
- iter_count  out  ADDR_W  completed sweeps in the current/last run

Behaviour:
- Reset (async, rst_n=0): state=IDLE. rd_addr=0, rd_valid=0, write_address=0, w_en=0, busy=0, done=0, converged=0, iter_count=0. Delay pipeline cleared.
- Pages: page bit p = iter_count[0]; read page base = p·2^(ADDR_W-1); write page = other page. rd_addr = {p, vertex v}; write_address = {~p, v}.
- FSM states: IDLE, READ, DRAIN, CHECK, DONE.
- IDLE:
  - start=1 → READ next cycle; clears iter_count, converged, sweep change flag, v.
  - start while busy is ignored.
- READ: one read per cycle. rd_valid=1, rd_addr={p,v}, v = 0..N_VERT-1. After v=N_VERT-1 → DRAIN.
- Write timing:
  - Read issued in cycle t for vertex v produces w_en=1 with write_address={~p,v} in cycle t+L, L=RD_LAT+DP_LAT.
  - Implemented as an L-deep shift register of {valid, v, p}.
  - No other cycle asserts w_en.
- Change flag: when w_en=1 and dp_changed=1, the sweep change flag sets. It is cleared on entry to each READ.
- DRAIN: stay until the delay pipeline holds no valid entry (last write has occurred) → CHECK.
- CHECK (1 cycle): iter_count++.
  - Change flag=0 → DONE with converged=1.
  - Else new iter_count == MAX_ITER → DONE with converged=0.
  - Else → READ; v reset, page flips.
- DONE: done=1 for one cycle → IDLE. busy drops in IDLE.
- Sweep length = N_VERT + L + 1 cycles; defaults give 13.
- abort=1 in any state:
  - next cycle IDLE, delay pipeline flushed, so no w_en after the abort cycle.
  - done not pulsed; iter_count holds; converged=0.
- abort and start together in IDLE: abort wins, stay IDLE.
- dp_changed is ignored when w_en=0.

Test Plan:
- Reset mid-READ: assert rst_n=0 at sweep cycle 3 → all outputs 0 immediately, state IDLE. No w_en after release until a new start.
- Default params, start, dp_changed=1 on every write:
  - Sweep 0: rd_addr 0..7 (page 0) in cycles 0..7; w_en in cycles 4..11 with write_address 512..519.
  - Sweep 1: reads 512..519, writes 0..7.
  - After 7 sweeps: done at cycle 91, iter_count=7, converged=0.
- dp_changed=1 only in sweep 0, 0 thereafter → done after sweep 1 CHECK (cycle 26), iter_count=2, converged=1.
- abort in cycle 6 of sweep 0 → w_en seen in cycles 4,5,6 only. busy=0 from cycle 7, done never pulses, iter_count=0.
- start held high through the whole run and pulsed again while busy → exactly one run. A new run starts only when start is sampled in IDLE after done.
- RD_LAT=2, DP_LAT=1: every write_address equals the read address of 3 cycles earlier with the page bit inverted. Sweep length = 12 cycles.
